// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: 2-flop row synchroniser, column scan,
// press/release debounce, and one registered ready pulse per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20
) (
  input  logic       Clock,
  input  logic       clearIn,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] tecla,
  output logic       ready,
  output logic [1:0] dbg_state_o
);

  localparam int CNT_MAX = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_EMIT     = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, rs_q;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    tecla_q, tecla_d;
  logic          ready_q, ready_d;

  function automatic logic single_low(input logic [3:0] pat);
    return pat inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] pat);
    case (pat)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hC;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hE;
      4'hC: return 4'hF;
      4'hD: return 4'h0;
      4'hE: return 4'hD;
      default: return 4'hA;
    endcase
  endfunction

  always_ff @(posedge Clock or negedge clearIn) begin
    if (!clearIn) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
      state_q <= S_SCAN;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      row_q   <= 4'hF;
      tecla_q <= 4'h0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= rows;
      rs_q    <= sync1_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      tecla_q <= tecla_d;
      ready_q <= ready_d;
    end
  end

  // One shared counter: dwell time in SCAN, stable-run length in DEBOUNCE/HOLD.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    tecla_d = tecla_q;
    ready_d = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (single_low(rs_q)) begin
            row_d   = rs_q;
            state_d = S_DEBOUNCE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DEBOUNCE: begin
        if (rs_q == row_q) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            state_d = S_EMIT;
            ready_d = 1'b1;
            tecla_d = key_code(row_index(row_q), idx_q);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d   = '0;
          state_d = S_SCAN;
          idx_d   = idx_q + 2'd1;
        end
      end
      S_EMIT: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      default: begin
        if (rs_q == 4'hF) begin
          if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            state_d = S_SCAN;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
    endcase
  end

  // ready is a one-cycle strobe with no back-pressure: tecla is valid in the
  // ready cycle and holds that value until the next accepted press.
  always_comb begin
    cols        = ~(4'b0001 << idx_q);
    tecla       = tecla_q;
    ready       = ready_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed keypad scenarios plus random presses,
// checked every cycle against a run-length/elapsed-time model of the scanner.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int M_SCAN = 0, M_CONF = 1, M_EMIT = 2, M_HOLD = 3;

  logic        Clock   = 1'b0;
  logic        clearIn = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  tecla;
  logic        ready;
  logic [1:0]  dbg_state;
  logic [15:0] keys_down = '0;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  // behavioural model state
  int         m_mode, m_col, m_elapsed, m_run;
  logic [3:0] m_sync0, m_sync1, m_latched, m_tecla;
  logic       m_ready;
  logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hE,
                               4'hF, 4'h0, 4'hD, 4'hA};
  logic [3:0] rot_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 Clock = ~Clock;

  // Physical keypad: a row reads low when a pressed key joins it to a low column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      if ((keys_down[r*4 +: 4] & ~cols) != 4'h0) rows[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB)) dut (
    .Clock      (Clock),
    .clearIn    (clearIn),
    .rows       (rows),
    .cols       (cols),
    .tecla      (tecla),
    .ready      (ready),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_row(input logic [3:0] v);
    int zeros = 0;
    int idx = -1;
    for (int i = 0; i < 4; i++)
      if (!v[i]) begin
        zeros++;
        idx = i;
      end
    return (zeros == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    m_mode = M_SCAN; m_col = 0; m_elapsed = 0; m_run = 0;
    m_sync0 = 4'hF; m_sync1 = 4'hF; m_latched = 4'hF;
    m_tecla = 4'h0; m_ready = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] rs;
    rs = m_sync1;
    m_ready = 1'b0;
    case (m_mode)
      M_SCAN: begin
        if (m_elapsed % SCAN_DIV == SCAN_DIV - 1) begin
          if (low_row(rs) >= 0) begin
            m_mode = M_CONF; m_latched = rs; m_run = 0;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
        m_elapsed++;
      end
      M_CONF: begin
        if (rs == m_latched) begin
          m_run++;
          if (m_run == DEB) begin
            m_mode = M_EMIT; m_ready = 1'b1;
            m_tecla = key_tab[low_row(m_latched) * 4 + m_col];
          end
        end else begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_elapsed = 0;
        end
      end
      M_EMIT: begin
        m_mode = M_HOLD; m_run = 0;
      end
      default: begin
        m_run = (rs == 4'hF) ? m_run + 1 : 0;
        if (m_run == DEB) begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_elapsed = 0;
        end
      end
    endcase
    m_sync1 = m_sync0;
    m_sync0 = rows;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clock or negedge clearIn);
      if (!clearIn) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [3:0] exp_cols;
    forever begin
      @(negedge Clock);
      exp_cols = 4'hF;
      exp_cols[m_col] = 1'b0;
      check("cols", cols, exp_cols);
      check("ready", ready, m_ready);
      check("tecla", tecla, m_tecla);
      if (ready) pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    keys_down[r*4 + c] = v;
  endtask

  task automatic set_reset(input logic v);
    @(negedge Clock);
    #2 clearIn = v;
  endtask

  initial begin
    int base;
    int guard;

    // 1: reset values, then column rotation every SCAN_DIV cycles
    tick(3);
    check("rst_cols", cols, 4'b1110);
    check("rst_ready", ready, 1'b0);
    check("rst_tecla", tecla, 4'h0);
    set_reset(1'b1);
    for (int m = 0; m < 16; m++) begin
      @(negedge Clock);
      check("rotate", cols, rot_tab[((m + 1) / 4) % 4]);
    end

    // 2: key 8 held long -> one pulse only
    base = pulses;
    set_key(2, 1, 1'b1);
    tick(150);
    check("k8_pulses", pulses - base, 1);
    check("k8_code", tecla, 4'd8);
    keys_down = '0;
    tick(40);

    // 3: ADD bouncing, then stable
    base = pulses;
    for (int i = 0; i < 10; i++) begin
      set_key(0, 3, (i % 2 == 0));
      tick(3);
    end
    check("bounce_quiet", pulses - base, 0);
    set_key(0, 3, 1'b1);
    tick(100);
    check("add_pulses", pulses - base, 1);
    check("add_code", tecla, 4'b1100);
    keys_down = '0;
    tick(40);

    // 4: key 5, short release glitches, then a real release and re-press
    base = pulses;
    set_key(1, 1, 1'b1);
    tick(60);
    check("k5_first", pulses - base, 1);
    check("k5_code", tecla, 4'd5);
    for (int i = 0; i < 3; i++) begin
      set_key(1, 1, 1'b0);
      tick(4);
      set_key(1, 1, 1'b1);
      tick(12);
    end
    check("k5_glitch", pulses - base, 1);
    set_key(1, 1, 1'b0);
    tick(30);
    set_key(1, 1, 1'b1);
    tick(60);
    check("k5_second", pulses - base, 2);
    check("k5_code2", tecla, 4'd5);
    keys_down = '0;
    tick(40);

    // 5: two rows low in column 2 -> ignored
    base = pulses;
    set_key(0, 2, 1'b1);
    set_key(1, 2, 1'b1);
    tick(80);
    check("ghost_quiet", pulses - base, 0);
    check("ghost_code", tecla, 4'd5);
    keys_down = '0;
    tick(20);

    // 6: reset during debounce of SAVE
    base = pulses;
    set_key(3, 0, 1'b1);
    guard = 0;
    while (m_mode != M_CONF && guard < 100) begin
      tick(1);
      guard++;
    end
    check("save_reached_debounce", (guard < 100), 1'b1);
    tick(3);
    set_reset(1'b0);
    tick(2);
    check("mid_rst_cols", cols, 4'b1110);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_tecla", tecla, 4'h0);
    set_reset(1'b1);
    tick(100);
    check("save_pulses", pulses - base, 1);
    check("save_code", tecla, 4'b1111);
    keys_down = '0;
    tick(40);

    // random presses, bounces and multi-key combinations
    for (int ep = 0; ep < 40; ep++) begin
      keys_down = '0;
      keys_down[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys_down[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        logic [15:0] held;
        held = keys_down;
        for (int b = 0; b < 6; b++) begin
          keys_down = (b % 2 == 0) ? 16'h0 : held;
          tick($urandom_range(1, 5));
        end
        keys_down = held;
      end
      tick($urandom_range(2, 90));
      keys_down = '0;
      tick($urandom_range(2, 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
